// File: rtl/mem_rr_scheduler.sv
// Round-robin arbiter sharing one mem_ctrl port between N_SRC requesters.
// One transaction in flight at a time, with a watchdog that aborts hung transactions.
module mem_rr_scheduler #(
    parameter int N_SRC   = 4,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 512,
    parameter int TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [2*N_SRC-1:0]        src_op,
    input  logic [N_SRC*ADDR_W-1:0]   src_addr,
    input  logic [N_SRC*DATA_W-1:0]   src_wdata,
    output logic [DATA_W-1:0]         src_rdata,
    output logic [N_SRC-1:0]          src_tx_done,
    output logic [N_SRC-1:0]          src_rd_valid,
    output logic [N_SRC-1:0]          src_err,
    output logic [1:0]                mem_op,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic                      mem_ready,
    input  logic [DATA_W-1:0]         mem_rdata,
    input  logic                      mem_tx_done,
    input  logic                      mem_rd_valid,
    output logic [N_SRC-1:0]          grant
);

    localparam int IDX_W = $clog2(N_SRC);
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_WR   = 2'b10;

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RELEASE} state_t;

    state_t            state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  owner;
    logic [WD_W-1:0]   wd;
    logic              rd_op;
    logic              rd_seen;

    logic [N_SRC-1:0]  req;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_valid;
    logic              wd_expire;

    function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int k);
        int sum;
        sum = int'(base) + k;
        if (sum >= N_SRC) sum = sum - N_SRC;
        return IDX_W'(sum);
    endfunction

    // Reserved op 11 counts as no request.
    always_comb begin
        req = '0;
        for (int i = 0; i < N_SRC; i++)
            req[i] = (src_op[2*i +: 2] == OP_RD) || (src_op[2*i +: 2] == OP_WR);
    end

    // Scan from the far end so the last hit is the first requester after rr_ptr.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (req[rr_index(rr_ptr, k)]) begin
                pick_valid = 1'b1;
                pick_idx   = rr_index(rr_ptr, k);
            end
        end
    end

    assign wd_expire = (TIMEOUT != 0) && (wd == WD_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            wd           <= '0;
            rd_op        <= 1'b0;
            rd_seen      <= 1'b0;
            mem_op       <= OP_NONE;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            src_rdata    <= '0;
            src_tx_done  <= '0;
            src_rd_valid <= '0;
            src_err      <= '0;
            grant        <= '0;
        end else begin
            // NOTE: pulse outputs default low every cycle; the branches below only raise them.
            src_tx_done  <= '0;
            src_rd_valid <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner <= pick_idx;
                        grant <= N_SRC'(1) << pick_idx;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!req[owner]) begin
                        grant  <= '0;
                        rr_ptr <= rr_index(owner, 1);
                        state  <= RELEASE;
                    end else if (mem_ready) begin
                        mem_op    <= src_op[2*owner +: 2];
                        mem_addr  <= src_addr[owner*ADDR_W +: ADDR_W];
                        mem_wdata <= src_wdata[owner*DATA_W +: DATA_W];
                        rd_op     <= (src_op[2*owner +: 2] == OP_RD);
                        rd_seen   <= 1'b0;
                        wd        <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    wd <= wd + 1'b1;
                    if (mem_rd_valid && rd_op) begin
                        rd_seen   <= 1'b1;
                        src_rdata <= mem_rdata;
                    end
                    // Completion is tested first so it wins over a same-cycle expiry.
                    if (mem_tx_done) begin
                        src_tx_done[owner]  <= 1'b1;
                        src_rd_valid[owner] <= rd_op && (rd_seen || mem_rd_valid);
                        mem_op              <= OP_NONE;
                        grant               <= '0;
                        rr_ptr              <= rr_index(owner, 1);
                        state               <= RELEASE;
                    end else if (wd_expire) begin
                        src_err[owner]      <= 1'b1;
                        src_tx_done[owner]  <= 1'b1;
                        mem_op              <= OP_NONE;
                        grant               <= '0;
                        rr_ptr              <= rr_index(owner, 1);
                        state               <= RELEASE;
                    end
                end
                RELEASE: begin
                    wd    <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_rr_scheduler.sv
// Directed bench for mem_rr_scheduler: requester and mem_ctrl models plus an
// issue/completion scoreboard.
module tb_mem_rr_scheduler;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 512;
    localparam int TO = 16;

    typedef struct {
        int              src;
        logic [1:0]      op;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   wdata;
    } iss_t;

    typedef struct {
        int              src;
        logic            rd;
        logic [DW-1:0]   rdata;
        logic            err;
    } cmp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [2*N-1:0]    src_op;
    logic [N*AW-1:0]   src_addr;
    logic [N*DW-1:0]   src_wdata;
    logic [DW-1:0]     src_rdata;
    logic [N-1:0]      src_tx_done, src_rd_valid, src_err, grant;
    logic [1:0]        mem_op;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_ready;
    logic [DW-1:0]     mem_rdata = '0;
    logic              mem_tx_done = 1'b0;
    logic              mem_rd_valid = 1'b0;

    int checks = 0;
    int errors = 0;

    iss_t exp_iss[$];
    cmp_t exp_cmp[$];

    logic [1:0]    rq_op    [N];
    logic [AW-1:0] rq_addr  [N];
    logic [DW-1:0] rq_wdata [N];
    int            rq_tgt   [N];
    int            done_cnt [N];

    int            rs_delay [N];
    bit            rs_en    [N];
    int            rs_mode  [N];
    logic [DW-1:0] rs_data  [N];
    bit            stray = 1'b0;

    mem_rr_scheduler #(.N_SRC(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .src_op(src_op), .src_addr(src_addr), .src_wdata(src_wdata),
        .src_rdata(src_rdata), .src_tx_done(src_tx_done), .src_rd_valid(src_rd_valid),
        .src_err(src_err), .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_tx_done(mem_tx_done),
        .mem_rd_valid(mem_rd_valid), .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Requester model: a source holds its op until it has seen rq_tgt completions.
    always_comb begin
        src_op    = '0;
        src_addr  = '0;
        src_wdata = '0;
        for (int i = 0; i < N; i++) begin
            if (done_cnt[i] < rq_tgt[i]) src_op[2*i +: 2] = rq_op[i];
            src_addr[i*AW +: AW]  = rq_addr[i];
            src_wdata[i*DW +: DW] = rq_wdata[i];
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < N; i++)
            if (src_tx_done[i] === 1'b1) done_cnt[i]++;
    end

    // mem_ctrl model; rs_mode: 0 rd_valid with done, 1 rd_valid early, 2 never rd_valid.
    bit         rs_act = 1'b0;
    bit         rs_rd = 1'b0;
    int         rs_cnt = 0;
    int         rs_src = 0;
    logic [1:0] rs_prev = 2'b00;

    always @(negedge clk) begin
        mem_tx_done  = 1'b0;
        mem_rd_valid = 1'b0;
        if (mem_op == 2'b00) rs_act = 1'b0;
        else if (rs_prev == 2'b00 && !rs_act) begin
            rs_act = 1'b1;
            rs_cnt = 0;
            rs_rd  = (mem_op == 2'b01);
            rs_src = 0;
            for (int i = N - 1; i >= 0; i--) if (grant[i]) rs_src = i;
        end
        if (rs_act && rs_en[rs_src]) begin
            if (rs_rd && rs_mode[rs_src] == 1 && rs_cnt == 0) begin
                mem_rd_valid = 1'b1;
                mem_rdata    = rs_data[rs_src];
            end
            if (rs_cnt == rs_delay[rs_src] - 1) begin
                mem_tx_done = 1'b1;
                if (rs_rd && rs_mode[rs_src] == 0) begin
                    mem_rd_valid = 1'b1;
                    mem_rdata    = rs_data[rs_src];
                end
                rs_act = 1'b0;
            end
            rs_cnt++;
        end else if (!rs_act && stray) begin
            mem_rd_valid = 1'b1;
            mem_rdata    = {16{32'hDEADBEEF}};
        end
        rs_prev = mem_op;
    end

    // Scoreboard monitors: issue edges on mem_op and completion pulses.
    logic [1:0] mon_prev = 2'b00;
    logic [N-1:0] exp_err = '0;
    logic [N-1:0] mon_oh;
    iss_t mon_e;
    cmp_t mon_c;

    always @(negedge clk) begin
        if (!rst_n) exp_err = '0;
        if (mem_op != 2'b00 && mon_prev == 2'b00) begin
            if (exp_iss.size() == 0) check("unexpected_issue", mem_op, 2'b00);
            else begin
                mon_e = exp_iss.pop_front();
                check("issue_op", mem_op, mon_e.op);
                check("issue_addr", mem_addr, mon_e.addr);
                check("issue_wdata", mem_wdata, mon_e.wdata);
                check("issue_grant", grant, N'(1) << mon_e.src);
            end
        end
        mon_prev = mem_op;
        if (src_tx_done != '0) begin
            if (exp_cmp.size() == 0) check("unexpected_done", src_tx_done, '0);
            else begin
                mon_c  = exp_cmp.pop_front();
                mon_oh = N'(1) << mon_c.src;
                check("done_src", src_tx_done, mon_oh);
                check("done_rd_valid", src_rd_valid, mon_c.rd ? mon_oh : '0);
                if (mon_c.rd) check("done_rdata", src_rdata, mon_c.rdata);
                if (mon_c.err) exp_err = exp_err | mon_oh;
                check("done_err", src_err, exp_err);
            end
        end else if (src_rd_valid != '0) begin
            check("stray_rd_valid", src_rd_valid, '0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start(input int i, input logic [1:0] op, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int n);
        rq_op[i]    = op;
        rq_addr[i]  = addr;
        rq_wdata[i] = wdata;
        rq_tgt[i]   = done_cnt[i] + n;
    endtask

    task automatic cfg(input int i, input int delay, input bit en, input int mode,
                       input logic [DW-1:0] data);
        rs_delay[i] = delay;
        rs_en[i]    = en;
        rs_mode[i]  = mode;
        rs_data[i]  = data;
    endtask

    task automatic push_exp(input int i, input bit with_cmp);
        iss_t e;
        cmp_t c;
        e.src = i; e.op = rq_op[i]; e.addr = rq_addr[i]; e.wdata = rq_wdata[i];
        exp_iss.push_back(e);
        if (with_cmp) begin
            c.src   = i;
            c.rd    = (rq_op[i] == 2'b01) && rs_en[i] && (rs_mode[i] != 2);
            c.rdata = rs_data[i];
            c.err   = !rs_en[i];
            exp_cmp.push_back(c);
        end
    endtask

    task automatic drain(input string tag, input int budget);
        for (int c = 0; c < budget && exp_cmp.size() != 0; c++) @(negedge clk);
        check(tag, exp_cmp.size(), 0);
        cyc(2);
    endtask

    task automatic wait_issue(input string tag);
        for (int c = 0; c < 20 && mem_op == 2'b00; c++) @(negedge clk);
        check(tag, (mem_op != 2'b00), 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            start(i, 2'b00, '0, '0, 0);
            cfg(i, 3, 1'b1, 0, '0);
        end
        cyc(2);
        check("rst_mem_op", mem_op, 2'b00);
        check("rst_mem_addr", mem_addr, '0);
        check("rst_mem_wdata", mem_wdata, '0);
        check("rst_src_rdata", src_rdata, '0);
        check("rst_tx_done", src_tx_done, '0);
        check("rst_rd_valid", src_rd_valid, '0);
        check("rst_err", src_err, '0);
        check("rst_grant", grant, '0);
        rst_n = 1'b1;
        cyc(2);

        // Single read from src1, 2-cycle issue latency.
        cfg(1, 5, 1'b1, 0, {16{32'hA5A5A5A5}});
        start(1, 2'b01, 64'h1000, {16{32'h11111111}}, 1);
        push_exp(1, 1'b1);
        cyc(1);
        check("rd_lat1_mem_op", mem_op, 2'b00);
        check("rd_lat1_grant", grant, 4'b0010);
        cyc(1);
        check("rd_lat2_mem_op", mem_op, 2'b01);
        drain("rd_complete", 40);
        check("rd_gap_mem_op", mem_op, 2'b00);

        // Backpressure on src2; completion lands exactly on the 16th BUSY cycle.
        mem_ready = 1'b0;
        cfg(2, 16, 1'b1, 0, {16{32'h22220000}});
        start(2, 2'b01, 64'h2000, {16{32'h22222222}}, 1);
        push_exp(2, 1'b1);
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            check("bp_hold_mem_op", mem_op, 2'b00);
        end
        check("bp_grant", grant, 4'b0100);
        mem_ready = 1'b1;
        cyc(1);
        check("bp_issue", mem_op, 2'b01);
        drain("bp_complete", 60);

        // Reset restores rr_ptr=0; four continuous writers served 0,1,2,3,0,1.
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) cfg(i, 3, 1'b1, 0, '0);
        start(0, 2'b10, 64'h0100, {16{32'h0A0A0A0A}}, 2);
        start(1, 2'b10, 64'h0200, {16{32'h1B1B1B1B}}, 2);
        start(2, 2'b10, 64'h0300, {16{32'h2C2C2C2C}}, 1);
        start(3, 2'b10, 64'h0400, {16{32'h3D3D3D3D}}, 1);
        push_exp(0, 1'b1); push_exp(1, 1'b1); push_exp(2, 1'b1);
        push_exp(3, 1'b1); push_exp(0, 1'b1); push_exp(1, 1'b1);
        drain("rr_complete", 200);

        // Timeout on src0; src1 is served next.
        cfg(0, 3, 1'b0, 0, {16{32'h30303030}});
        cfg(1, 3, 1'b1, 0, '0);
        start(0, 2'b01, 64'h3000, {16{32'h33333333}}, 1);
        start(1, 2'b10, 64'h3100, {16{32'h31313131}}, 1);
        push_exp(0, 1'b1); push_exp(1, 1'b1);
        wait_issue("to_issue");
        cyc(15);
        check("to_err_before", src_err[0], 1'b0);
        check("to_done_before", src_tx_done[0], 1'b0);
        cyc(1);
        check("to_err_set", src_err[0], 1'b1);
        check("to_done_pulse", src_tx_done[0], 1'b1);
        check("to_no_rd_valid", src_rd_valid[0], 1'b0);
        drain("to_complete", 80);

        // Completion on the watchdog terminal count wins.
        cfg(3, 16, 1'b1, 0, {16{32'h3C3C3C3C}});
        start(3, 2'b01, 64'h4000, '0, 1);
        push_exp(3, 1'b1);
        drain("simul_complete", 60);

        // Stray mem_rd_valid while idle must not qualify a later read.
        stray = 1'b1;
        cyc(2);
        stray = 1'b0;
        cyc(1);
        cfg(0, 4, 1'b1, 2, {16{32'h50505050}});
        start(0, 2'b01, 64'h5000, '0, 1);
        push_exp(0, 1'b1);
        drain("stray_complete", 40);

        // Read data arriving before mem_tx_done is still delivered.
        cfg(1, 4, 1'b1, 1, {16{32'h61616161}});
        start(1, 2'b01, 64'h6000, '0, 1);
        push_exp(1, 1'b1);
        drain("early_rd_complete", 40);

        // Cancel in ISSUE: src2 drops its op while mem_ready is low.
        mem_ready = 1'b0;
        start(2, 2'b01, 64'h7000, '0, 1);
        cyc(3);
        check("cancel_grant_held", grant, 4'b0100);
        rq_tgt[2] = done_cnt[2];
        cyc(1);
        check("cancel_grant_clear", grant, 4'b0000);
        check("cancel_mem_op", mem_op, 2'b00);
        mem_ready = 1'b1;
        cyc(3);
        check("cancel_no_issue", mem_op, 2'b00);
        cfg(2, 3, 1'b1, 0, '0);
        cfg(3, 3, 1'b1, 0, '0);
        start(2, 2'b10, 64'h7200, {16{32'h72727272}}, 1);
        start(3, 2'b10, 64'h7300, {16{32'h73737373}}, 1);
        push_exp(3, 1'b1); push_exp(2, 1'b1);
        drain("post_cancel_complete", 60);

        // Reset mid-BUSY: no completion, then src0 wins a 4-way contention.
        cfg(1, 3, 1'b0, 0, '0);
        start(1, 2'b10, 64'h8000, {16{32'h81818181}}, 1);
        push_exp(1, 1'b0);
        wait_issue("mid_rst_issue");
        cyc(3);
        rst_n = 1'b0;
        cyc(1);
        check("mid_rst_mem_op", mem_op, 2'b00);
        check("mid_rst_grant", grant, '0);
        check("mid_rst_done", src_tx_done, '0);
        check("mid_rst_err", src_err, '0);
        rq_tgt[1] = done_cnt[1];
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) cfg(i, 3, 1'b1, 0, '0);
        start(0, 2'b10, 64'h9000, {16{32'h90909090}}, 1);
        start(1, 2'b10, 64'h9100, {16{32'h91919191}}, 1);
        start(2, 2'b10, 64'h9200, {16{32'h92929292}}, 1);
        start(3, 2'b10, 64'h9300, {16{32'h93939393}}, 1);
        push_exp(0, 1'b1); push_exp(1, 1'b1); push_exp(2, 1'b1); push_exp(3, 1'b1);
        drain("post_rst_complete", 120);

        check("iss_queue_empty", exp_iss.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
